// File: rtl/decode_queue_if.sv
// Micro-op types and the IF -> decode queue -> EX signal bundle.
// A transfer happens on an edge where valid && ready; ready may depend on the consumer's ready.
typedef enum logic [3:0] {
   ALU_ADD  = 4'd0,
   ALU_SUB  = 4'd1,
   ALU_SLL  = 4'd2,
   ALU_SLT  = 4'd3,
   ALU_SLTU = 4'd4,
   ALU_XOR  = 4'd5,
   ALU_SRL  = 4'd6,
   ALU_SRA  = 4'd7,
   ALU_OR   = 4'd8,
   ALU_AND  = 4'd9
} alu_op_t;

typedef struct packed {
   logic        valid;
   logic [6:0]  opcode;
   alu_op_t     alu_op;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [2:0]  funct3;
   logic [31:0] imm;
   logic        is_immediate;
   logic        uses_rs1;
   logic        uses_rs2;
   logic        writes_rd;
} uop_t;

interface decode_queue_if #(
   parameter int DEPTH = 2
);
   localparam int CW = $clog2(DEPTH + 1);

   logic          i_if_valid;
   logic          o_if_ready;
   logic [31:0]   i_if_pc;
   logic [31:0]   i_if_instr;
   logic          i_flush;
   logic          o_dec_valid;
   logic          i_ex_ready;
   uop_t          o_uop;
   logic [31:0]   o_dec_pc;
   logic          o_illegal;
   logic [CW-1:0] o_count;

   modport master (
      output i_if_valid, i_if_pc, i_if_instr, i_flush, i_ex_ready,
      input  o_if_ready, o_dec_valid, o_uop, o_dec_pc, o_illegal, o_count
   );

   modport slave (
      input  i_if_valid, i_if_pc, i_if_instr, i_flush, i_ex_ready,
      output o_if_ready, o_dec_valid, o_uop, o_dec_pc, o_illegal, o_count
   );
endinterface

// File: rtl/decode_queue.sv
// Circular instruction buffer between fetch and execute; the head entry is
// decoded combinationally into an RV32I micro-op.
module decode_queue #(
   parameter int DEPTH   = 2,
   parameter bit EN_CTRL = 1'b1
) (
   input logic           clk,
   input logic           rst,
   decode_queue_if.slave q
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_JALR   = 7'h67;

   logic [31:0]   pc_mem    [DEPTH];
   logic [31:0]   instr_mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic push;
   logic pop;
   logic dec_valid;

   assign dec_valid     = (count != '0) && !q.i_flush;
   assign q.o_if_ready  = !q.i_flush && ((count < FULL) || q.i_ex_ready);
   assign q.o_dec_valid = dec_valid;
   assign q.o_count     = count;
   assign push          = q.i_if_valid && q.o_if_ready;
   assign pop           = dec_valid && q.i_ex_ready;

   // Flush wins over any push or pop presented in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (q.i_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]    <= q.i_if_pc;
         instr_mem[wr_ptr] <= q.i_if_instr;
      end
   end

   function automatic alu_op_t alu_from_f3(input logic [2:0] f3);
      case (f3)
         3'd0:    alu_from_f3 = ALU_ADD;
         3'd1:    alu_from_f3 = ALU_SLL;
         3'd2:    alu_from_f3 = ALU_SLT;
         3'd3:    alu_from_f3 = ALU_SLTU;
         3'd4:    alu_from_f3 = ALU_XOR;
         3'd5:    alu_from_f3 = ALU_SRL;
         3'd6:    alu_from_f3 = ALU_OR;
         default: alu_from_f3 = ALU_AND;
      endcase
   endfunction

   logic [31:0] head;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic        rd_nz;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   uop_t        dec;
   logic        dec_ill;

   assign head  = instr_mem[rd_ptr];
   assign f3    = head[14:12];
   assign f7    = head[31:25];
   assign rd_nz = |head[11:7];
   assign imm_i = {{20{head[31]}}, head[31:20]};
   assign imm_s = {{20{head[31]}}, head[31:25], head[11:7]};
   assign imm_b = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
   assign imm_u = {head[31:12], 12'b0};
   assign imm_j = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};

   always_comb begin
      dec        = '0;
      dec_ill    = 1'b0;
      dec.valid  = 1'b1;
      dec.opcode = head[6:0];
      dec.rd     = head[11:7];
      dec.rs1    = head[19:15];
      dec.rs2    = head[24:20];
      dec.funct3 = f3;
      dec.alu_op = ALU_ADD;
      case (head[6:0])
         OPC_OP: begin
            dec.uses_rs1  = 1'b1;
            dec.uses_rs2  = 1'b1;
            dec.writes_rd = rd_nz;
            if (f7 == 7'h00)                      dec.alu_op = alu_from_f3(f3);
            else if (f7 == 7'h20 && f3 == 3'd0)   dec.alu_op = ALU_SUB;
            else if (f7 == 7'h20 && f3 == 3'd5)   dec.alu_op = ALU_SRA;
            else                                  dec_ill    = 1'b1;
         end
         OPC_OP_IMM: begin
            dec.is_immediate = 1'b1;
            dec.imm          = imm_i;
            dec.uses_rs1     = 1'b1;
            dec.writes_rd    = rd_nz;
            dec.alu_op       = alu_from_f3(f3);
            // Only the shift forms constrain the upper immediate bits.
            if (f3 == 3'd1 && f7 != 7'h00) dec_ill = 1'b1;
            if (f3 == 3'd5) begin
               if (f7 == 7'h20)      dec.alu_op = ALU_SRA;
               else if (f7 != 7'h00) dec_ill    = 1'b1;
            end
         end
         OPC_LUI, OPC_AUIPC: begin
            dec.is_immediate = 1'b1;
            dec.imm          = imm_u;
            dec.writes_rd    = rd_nz;
         end
         OPC_LOAD: begin
            dec.is_immediate = 1'b1;
            dec.imm          = imm_i;
            dec.uses_rs1     = 1'b1;
            dec.writes_rd    = rd_nz;
            if (!EN_CTRL || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) dec_ill = 1'b1;
         end
         OPC_STORE: begin
            dec.is_immediate = 1'b1;
            dec.imm          = imm_s;
            dec.uses_rs1     = 1'b1;
            dec.uses_rs2     = 1'b1;
            if (!EN_CTRL || f3[2] || f3 == 3'd3) dec_ill = 1'b1;
         end
         OPC_BRANCH: begin
            dec.imm      = imm_b;
            dec.uses_rs1 = 1'b1;
            dec.uses_rs2 = 1'b1;
            case (f3[2:1])
               2'b00:   dec.alu_op = ALU_SUB;
               2'b10:   dec.alu_op = ALU_SLT;
               2'b11:   dec.alu_op = ALU_SLTU;
               default: dec_ill    = 1'b1;
            endcase
            if (!EN_CTRL) dec_ill = 1'b1;
         end
         OPC_JAL: begin
            dec.is_immediate = 1'b1;
            dec.imm          = imm_j;
            dec.writes_rd    = rd_nz;
            if (!EN_CTRL) dec_ill = 1'b1;
         end
         OPC_JALR: begin
            dec.is_immediate = 1'b1;
            dec.imm          = imm_i;
            dec.uses_rs1     = 1'b1;
            dec.writes_rd    = rd_nz;
            if (!EN_CTRL || f3 != 3'd0) dec_ill = 1'b1;
         end
         default: dec_ill = 1'b1;
      endcase
   end

   // Illegal or absent heads present an all-zero micro-op so EX can trap on o_illegal.
   assign q.o_uop     = (dec_valid && !dec_ill) ? dec : '0;
   assign q.o_illegal = dec_valid && dec_ill;
   assign q.o_dec_pc  = pc_mem[rd_ptr];
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: a queue-plus-ISA model checked every cycle,
// with hand-computed expectations for the key scenarios.
module tb_decode_queue;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        flush;
   logic        ex_ready;

   int n_vec = 0;
   int n_err = 0;

   decode_queue_if #(.DEPTH(DEPTH)) qa ();
   decode_queue_if #(.DEPTH(DEPTH)) qb ();

   assign qa.i_if_valid = if_valid;
   assign qa.i_if_pc    = if_pc;
   assign qa.i_if_instr = if_instr;
   assign qa.i_flush    = flush;
   assign qa.i_ex_ready = ex_ready;
   assign qb.i_if_valid = if_valid;
   assign qb.i_if_pc    = if_pc;
   assign qb.i_if_instr = if_instr;
   assign qb.i_flush    = flush;
   assign qb.i_ex_ready = ex_ready;

   decode_queue #(.DEPTH(DEPTH), .EN_CTRL(1'b1)) dut_a (.clk(clk), .rst(rst), .q(qa.slave));
   decode_queue #(.DEPTH(DEPTH), .EN_CTRL(1'b0)) dut_b (.clk(clk), .rst(rst), .q(qb.slave));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic v, input logic [31:0] p, input logic [31:0] w,
                         input logic er, input logic fl);
      if_valid = v;
      if_pc    = p;
      if_instr = w;
      ex_ready = er;
      flush    = fl;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- ISA model ----------------
   alu_op_t by_f3 [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};

   function automatic void m_decode(input logic [31:0] w, input bit en_ctrl,
                                    output uop_t u, output bit ill);
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] ii, is_, ib, iu, ij;
      op  = w[6:0];
      f3  = w[14:12];
      f7  = w[31:25];
      ii  = 32'(signed'(w[31:20]));
      is_ = 32'(signed'({w[31:25], w[11:7]}));
      ib  = 32'(signed'({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      iu  = w & 32'hFFFF_F000;
      ij  = 32'(signed'({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      u = '0;
      ill = 1'b0;
      u.valid  = 1'b1;
      u.opcode = op;
      u.rd     = w[11:7];
      u.rs1    = w[19:15];
      u.rs2    = w[24:20];
      u.funct3 = f3;
      u.alu_op = ALU_ADD;
      if (!en_ctrl && (op inside {7'h03, 7'h23, 7'h63, 7'h6F, 7'h67})) ill = 1'b1;
      case (op)
         7'h33: begin
            u.uses_rs1 = 1; u.uses_rs2 = 1; u.writes_rd = (w[11:7] != 0);
            if (f7 == 0) u.alu_op = by_f3[f3];
            else if ({f7, f3} == {7'h20, 3'd0}) u.alu_op = ALU_SUB;
            else if ({f7, f3} == {7'h20, 3'd5}) u.alu_op = ALU_SRA;
            else ill = 1'b1;
         end
         7'h13: begin
            u.is_immediate = 1; u.imm = ii; u.uses_rs1 = 1; u.writes_rd = (w[11:7] != 0);
            u.alu_op = (f3 == 5 && f7 == 7'h20) ? ALU_SRA : by_f3[f3];
            if (f3 == 1 && f7 != 0) ill = 1'b1;
            if (f3 == 5 && !(f7 inside {7'h00, 7'h20})) ill = 1'b1;
         end
         7'h37, 7'h17: begin
            u.is_immediate = 1; u.imm = iu; u.writes_rd = (w[11:7] != 0);
         end
         7'h03: begin
            u.is_immediate = 1; u.imm = ii; u.uses_rs1 = 1; u.writes_rd = (w[11:7] != 0);
            if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ill = 1'b1;
         end
         7'h23: begin
            u.is_immediate = 1; u.imm = is_; u.uses_rs1 = 1; u.uses_rs2 = 1;
            if (!(f3 inside {3'd0, 3'd1, 3'd2})) ill = 1'b1;
         end
         7'h63: begin
            u.imm = ib; u.uses_rs1 = 1; u.uses_rs2 = 1;
            if (f3 inside {3'd0, 3'd1})      u.alu_op = ALU_SUB;
            else if (f3 inside {3'd4, 3'd5}) u.alu_op = ALU_SLT;
            else if (f3 inside {3'd6, 3'd7}) u.alu_op = ALU_SLTU;
            else ill = 1'b1;
         end
         7'h6F: begin
            u.is_immediate = 1; u.imm = ij; u.writes_rd = (w[11:7] != 0);
         end
         7'h67: begin
            u.is_immediate = 1; u.imm = ii; u.uses_rs1 = 1; u.writes_rd = (w[11:7] != 0);
            if (f3 != 0) ill = 1'b1;
         end
         default: ill = 1'b1;
      endcase
      if (ill) u = '0;
   endfunction

   // ---------------- queue model ----------------
   logic [63:0] exp_q [$];

   always @(posedge clk or posedge rst) begin
      if (rst || flush) begin
         exp_q.delete();
      end else begin
         bit m_pop, m_push;
         m_pop  = (exp_q.size() != 0) && ex_ready;
         m_push = if_valid && ((exp_q.size() < DEPTH) || ex_ready);
         if (m_pop) void'(exp_q.pop_front());
         if (m_push) exp_q.push_back({if_pc, if_instr});
      end
   end

   // ---------------- per-cycle compare ----------------
   uop_t        ua, ub;
   bit          ia, ib_;
   bit          mv, mr;
   logic [63:0] hd;

   always @(negedge clk) begin
      mv = (exp_q.size() != 0) && !flush;
      mr = !flush && ((exp_q.size() < DEPTH) || ex_ready);
      ua = '0; ub = '0; ia = 0; ib_ = 0; hd = '0;
      if (mv) begin
         hd = exp_q[0];
         m_decode(hd[31:0], 1'b1, ua, ia);
         m_decode(hd[31:0], 1'b0, ub, ib_);
      end
      chk("a_count",     qa.o_count,    exp_q.size());
      chk("a_dec_valid", qa.o_dec_valid, mv);
      chk("a_if_ready",  qa.o_if_ready, mr);
      chk("a_uop",       qa.o_uop,      ua);
      chk("a_illegal",   qa.o_illegal,  ia);
      chk("b_count",     qb.o_count,    exp_q.size());
      chk("b_dec_valid", qb.o_dec_valid, mv);
      chk("b_uop",       qb.o_uop,      ub);
      chk("b_illegal",   qb.o_illegal,  ib_);
      if (mv) begin
         chk("a_dec_pc", qa.o_dec_pc, hd[63:32]);
         chk("b_dec_pc", qb.o_dec_pc, hd[63:32]);
      end
   end

   logic [31:0] tbl [17] = '{
      32'h0020A423, 32'h010000EF, 32'h00008067, 32'h00009067, 32'h00001197,
      32'h40109093, 32'h4030D113, 32'hFFF0C213, 32'h00208463, 32'h0000B183,
      32'h00000073, 32'h402083B3, 32'h00208033, 32'h0020F463, 32'h0020A463,
      32'h0000D183, 32'h0020B423
   };

   initial begin
      rst = 1'b1;
      set_in(0, 0, 0, 0, 0);
      step();
      step();
      chk("rst_dec_valid", qa.o_dec_valid, 1'b0);
      chk("rst_count",     qa.o_count,     0);
      chk("rst_illegal",   qa.o_illegal,   1'b0);
      chk("rst_uop",       qa.o_uop,       '0);
      chk("rst_if_ready",  qa.o_if_ready,  1'b1);
      rst = 1'b0;
      step();

      // ADDI x1,x0,5 pushed with EX ready: visible the next cycle, not before.
      set_in(1, 32'h100, 32'h00500093, 1, 0);
      #1 chk("addi_no_bypass", qa.o_dec_valid, 1'b0);
      step();
      set_in(0, 0, 0, 0, 0);
      #1;
      chk("addi_valid", qa.o_dec_valid,    1'b1);
      chk("addi_alu",   qa.o_uop.alu_op,   ALU_ADD);
      chk("addi_imm",   qa.o_uop.imm,      32'd5);
      chk("addi_wrd",   qa.o_uop.writes_rd, 1'b1);
      chk("addi_pc",    qa.o_dec_pc,       32'h100);
      chk("addi_count", qa.o_count,        1);
      set_in(0, 0, 0, 1, 0);
      step();

      // Fill to DEPTH with EX stalled, then push and pop together.
      set_in(1, 32'h200, 32'h4020D1B3, 0, 0); step();
      set_in(1, 32'h204, 32'h022081B3, 0, 0); step();
      set_in(1, 32'h208, 32'hFE20CCE3, 0, 0);
      #1;
      chk("full_ready", qa.o_if_ready,  1'b0);
      chk("full_count", qa.o_count,     2);
      chk("sra_alu",    qa.o_uop.alu_op, ALU_SRA);
      step();
      set_in(1, 32'h208, 32'hFE20CCE3, 1, 0);
      #1 chk("full_pop_ready", qa.o_if_ready, 1'b1);
      step();
      set_in(0, 0, 0, 0, 0);
      #1;
      chk("pp_count",     qa.o_count,      2);
      chk("ill_flag",     qa.o_illegal,    1'b1);
      chk("ill_uop_vld",  qa.o_uop.valid,  1'b0);
      chk("ill_pc",       qa.o_dec_pc,     32'h204);
      set_in(0, 0, 0, 1, 0);
      step();
      set_in(0, 0, 0, 0, 0);
      #1;
      chk("blt_alu",   qa.o_uop.alu_op,    ALU_SLT);
      chk("blt_imm",   qa.o_uop.imm,       32'hFFFF_FFF8);
      chk("blt_wrd",   qa.o_uop.writes_rd, 1'b0);
      chk("blt_pc",    qa.o_dec_pc,        32'h208);
      chk("blt_noctl", qb.o_illegal,       1'b1);
      chk("blt_nouop", qb.o_uop,           '0);
      set_in(0, 0, 0, 1, 0);
      step();

      // Flush with two queued and an offer present.
      set_in(1, 32'h300, 32'h123452B7, 0, 0); step();
      set_in(1, 32'h304, 32'h0040A303, 0, 0); step();
      set_in(1, 32'h308, 32'h00500093, 0, 1);
      #1;
      chk("flush_valid", qa.o_dec_valid, 1'b0);
      chk("flush_ready", qa.o_if_ready,  1'b0);
      step();
      set_in(0, 0, 0, 0, 0);
      #1 chk("flush_count", qa.o_count, 0);

      // Asynchronous reset between edges.
      set_in(1, 32'h400, 32'h123452B7, 0, 0); step();
      set_in(1, 32'h404, 32'h0040A303, 0, 0); step();
      set_in(0, 0, 0, 0, 0);
      #1 chk("pre_rst_count", qa.o_count, 2);
      rst = 1'b1;
      #1;
      chk("arst_valid", qa.o_dec_valid, 1'b0);
      chk("arst_count", qa.o_count,     0);
      step();
      rst = 1'b0;
      step();

      // Mixed encodings streamed with varying offer/consume patterns.
      for (int i = 0; i < 17; i++) begin
         set_in((i % 4) != 3, 32'h1000 + 32'(4 * i), tbl[i], (i % 3) != 0, 0);
         step();
      end
      set_in(0, 0, 0, 1, 0);
      repeat (4) step();
      chk("drain_count", qa.o_count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameters: DEPTH, 2, buffer entries between IF and decode (power of 2, 2..16).
REQ-002 Parameters: EN_CTRL, 1, when 1 decode LOAD/STORE/BRANCH/JAL/JALR; when 0 those opcodes are illegal.
REQ-003 Ports: clk  in  1  sole clock, rising edge.
REQ-004 Ports: rst  in  1  asynchronous, active-high reset.
REQ-005 Ports: i_if_valid  in  1  IF offers an instruction.
REQ-006 Ports: o_if_ready  out  1  queue accepts the IF offer this cycle.
REQ-007 Ports: i_if_pc  in  32  PC of offered instruction.
REQ-008 Ports: i_if_instr  in  32  offered instruction word.
REQ-009 Ports: i_flush  in  1  synchronous discard of all queued instructions.
REQ-010 Ports: o_dec_valid  out  1  decoded head entry available.
REQ-011 Ports: i_ex_ready  in  1  EX consumes head entry this cycle.
REQ-012 Ports: o_uop  out  uop_t  decoded micro-op of head entry.
REQ-013 Ports: o_dec_pc  out  32  PC of head entry.
REQ-014 Ports: o_illegal  out  1  head entry is not a supported encoding.
REQ-015 Ports: o_count  out  $clog2(DEPTH+1)  current occupancy.

Function
REQ-016 Storage: DEPTH-entry circular FIFO of {pc, instr}; read/write pointers wrap modulo DEPTH; full/empty from occupancy counter, not pointer compare alone.
REQ-017 Push = i_if_valid && o_if_ready; pop = o_dec_valid && i_ex_ready.
REQ-018 o_if_ready = !i_flush && (o_count < DEPTH || i_ex_ready); push while full with simultaneous pop is legal, occupancy unchanged.
REQ-019 o_dec_valid = (o_count != 0) && !i_flush; decode is combinational from the registered head entry.
REQ-020 Latency: instruction pushed at edge N appears on o_dec_valid after edge N, earliest one cycle later; no same-cycle bypass from IF to output.
REQ-021 Ordering strictly FIFO; head outputs held stable while o_dec_valid && !i_ex_ready.
REQ-022 Flush: at the edge where i_flush=1, occupancy -> 0, pointers -> 0; any push or pop that cycle is discarded; flush takes priority over all.
REQ-023 Push to empty queue with simultaneous i_ex_ready: no pop (nothing valid), occupancy -> 1.
REQ-024 Fields: rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25]; immediates I/S/B/U/J per RV32I, sign-extended from bit 31.
REQ-025 OP: alu_op from {funct7[5],funct3}: 0000 ADD, 1000 SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 0101 SRL, 1101 SRA, 110 OR, 111 AND; funct7 other than 0x00/0x20, or 0x20 with funct3 not 000/101, is illegal.
REQ-026 OP-IMM: same table but funct3=000 always ADD; SLLI requires funct7=0x00; SRLI/SRAI require funct7 0x00/0x20; else illegal; is_immediate=1, imm=imm_i.
REQ-027 LUI/AUIPC: is_immediate=1, imm=imm_u, alu_op=ADD, uses_rs1=0, uses_rs2=0.
REQ-028 LOAD (EN_CTRL=1): imm_i, ADD, uses_rs1=1; funct3 in {000,001,010,100,101} else illegal.
REQ-029 STORE: imm_s, ADD, uses_rs1=1, uses_rs2=1, writes_rd=0; funct3 in {000,001,010} else illegal.
REQ-030 BRANCH: imm_b, uses_rs1=1, uses_rs2=1, writes_rd=0; alu_op SUB for 000/001, SLT for 100/101, SLTU for 110/111; 010/011 illegal.
REQ-031 JAL: imm_j, ADD, no rs uses; JALR: imm_i, ADD, uses_rs1=1, funct3 must be 000 else illegal.
REQ-032 writes_rd = (rd != 0) for all rd-writing classes; 0 otherwise.
REQ-033 Illegal entry: o_dec_valid=1, o_illegal=1, o_uop='0 (uop.valid=0), o_dec_pc valid; entry pops normally so EX can trap.
REQ-034 Legal entry: o_uop.valid=1, o_uop.opcode=instr[6:0], o_illegal=0; when o_dec_valid=0, o_uop='0, o_illegal=0.

Reset
REQ-035 rst=1 asynchronously clears pointers and occupancy; o_dec_valid=0, o_count=0, o_illegal=0, o_uop='0, o_if_ready=1 after reset with i_flush=0.
REQ-036 Reset mid-operation discards all entries; storage array contents need not be cleared; o_dec_pc is don't-care while o_dec_valid=0.

Verification
REQ-037 Push ADDI x1,x0,5 (0x00500093) pc=0x100, i_ex_ready=1 -> next cycle o_dec_valid=1, alu_op=ADD, imm=5, writes_rd=1, o_dec_pc=0x100.
REQ-038 DEPTH=2, i_ex_ready=0, push 3 -> o_count=2, o_if_ready=0 on third; then i_ex_ready=1 with push -> simultaneous push/pop, o_count stays 2, order preserved.
REQ-039 SRA x3,x1,x2 (0x4020D1B3) -> alu_op=SRA; funct7=0x01 on OP (0x022081B3) -> o_illegal=1, uop.valid=0.
REQ-040 BLT x1,x2,-8 (0xFE20CCE3) -> alu_op=SLT, imm=0xFFFFFFF8, writes_rd=0; with EN_CTRL=0 same word -> o_illegal=1.
REQ-041 Queue holding 2 entries, i_flush=1 with i_if_valid=1 -> o_dec_valid=0, o_if_ready=0 that cycle, o_count=0 next cycle.
REQ-042 Assert rst between edges with 2 entries queued -> o_dec_valid and o_count drop to 0 immediately, before next clk edge.
